// File: rtl/cam_capture_ctrl_pkg.sv
// Shared constants, FSM encoding and pixel conversion for the camera
// capture sequencer.
package cam_pkg;

    localparam int IMG_W     = 320;
    localparam int IMG_H     = 240;
    localparam int FRAME_PIX = IMG_W * IMG_H;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    function automatic logic [7:0] rgb565_to_rgb332(
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Camera input bus and frame buffer write port of the capture sequencer.
interface cam_capture_ctrl_if #(
    parameter int AW = 17,
    parameter int DW = 8
);
    logic          cam_pclk;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_px_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;

    modport master (
        output cam_pclk, cam_vsync, cam_href, cam_px_data,
        input  mem_wr_en, mem_addr, mem_data
    );

    modport slave (
        input  cam_pclk, cam_vsync, cam_href, cam_px_data,
        output mem_wr_en, mem_addr, mem_data
    );
endinterface

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer with a third flop for rise/fall detection.
module cam_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_lvl  = r_s2;
    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;
endmodule

// File: rtl/cam_capture_ctrl.sv
// Capture sequencer: camera RGB565 byte stream to RGB332 frame buffer
// writes, single-shot or live, with line-length error flag.
module cam_capture_ctrl #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int AW    = 17,
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    cam_capture_ctrl_if.slave bus,
    input  logic              cap_btn,
    input  logic              mode_live,
    output logic              frame_done,
    output logic              busy,
    output logic              err_line
);
    import cam_pkg::ST_IDLE;
    import cam_pkg::ST_ARM;
    import cam_pkg::ST_CAPTURE;
    import cam_pkg::ST_DONE;
    import cam_pkg::rgb565_to_rgb332;

    localparam int XW = $clog2(IMG_W + 1) + 1;
    localparam int YW = $clog2(IMG_H + 1) + 1;
    localparam logic [XW-1:0] X_END = XW'(IMG_W);
    localparam logic [YW-1:0] Y_END = YW'(IMG_H);

    logic w_pclk_lvl, w_pclk_rise, w_pclk_fall;
    logic w_vs_lvl, w_vs_rise, w_vs_fall;
    logic w_href_lvl, w_href_rise, w_href_fall;
    logic w_unused;

    logic [7:0]    r_d1, r_d2, r_hi;
    logic [1:0]    r_state, w_next;
    logic          r_btn, r_phase;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_row;
    logic          w_cap, w_arm_entry;

    cam_sync_edge u_pclk (
        .clk(clk), .rst(rst), .i_d(bus.cam_pclk),
        .o_lvl(w_pclk_lvl), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall)
    );
    cam_sync_edge u_vsync (
        .clk(clk), .rst(rst), .i_d(bus.cam_vsync),
        .o_lvl(w_vs_lvl), .o_rise(w_vs_rise), .o_fall(w_vs_fall)
    );
    cam_sync_edge u_href (
        .clk(clk), .rst(rst), .i_d(bus.cam_href),
        .o_lvl(w_href_lvl), .o_rise(w_href_rise), .o_fall(w_href_fall)
    );

    assign w_unused = ^{w_pclk_lvl, w_pclk_fall, w_vs_lvl, w_href_rise};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if ((cap_btn & ~r_btn) | mode_live) w_next = ST_ARM;
            ST_ARM:     if (w_vs_fall) w_next = ST_CAPTURE;
            ST_CAPTURE: if (w_vs_rise) w_next = ST_DONE;
            ST_DONE:    w_next = mode_live ? ST_ARM : ST_IDLE;
        endcase
    end

    assign w_cap       = (r_state == ST_CAPTURE);
    assign w_arm_entry = (w_next == ST_ARM) && (r_state != ST_ARM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d1          <= '0;
            r_d2          <= '0;
            r_hi          <= '0;
            r_state       <= ST_IDLE;
            r_btn         <= 1'b0;
            r_phase       <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_row         <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            err_line      <= 1'b0;
            bus.mem_wr_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_data  <= '0;
        end else begin
            r_d1          <= bus.cam_px_data;
            r_d2          <= r_d1;
            r_btn         <= cap_btn;
            r_state       <= w_next;
            busy          <= (w_next == ST_ARM) || (w_next == ST_CAPTURE);
            frame_done    <= (r_state == ST_DONE);
            bus.mem_wr_en <= 1'b0;
            if (w_arm_entry) begin
                r_x      <= '0;
                r_y      <= '0;
                r_row    <= '0;
                r_phase  <= 1'b0;
                err_line <= 1'b0;
            end else if (w_cap) begin
                if (w_href_fall) begin
                    if (r_x != X_END) err_line <= 1'b1;
                    r_x     <= '0;
                    r_phase <= 1'b0;
                    if (r_y != '1) r_y <= r_y + 1'b1;
                    if (r_y < Y_END) r_row <= r_row + AW'(IMG_W);
                end else if (!w_href_lvl) begin
                    r_phase <= 1'b0;
                end else if (w_pclk_rise) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_hi <= r_d2;
                    end else begin
                        // Overlong lines and rows past the frame keep counting but never write
                        bus.mem_wr_en <= (r_x < X_END) && (r_y < Y_END);
                        bus.mem_addr  <= r_row + AW'(r_x);
                        bus.mem_data  <= DW'(rgb565_to_rgb332(r_hi, r_d2));
                        if (r_x != '1) r_x <= r_x + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl on a reduced 16x8 frame.
module tb_cam_capture_ctrl;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int FR = W * H;

    typedef struct {
        bit live;
        int nfr;
        int odd_row;
        int odd_bytes;
        int exp_wr;
        int exp_done;
        bit exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cap_btn = 1'b0;
    logic mode_live = 1'b0;
    logic frame_done, busy, err_line;

    int checks = 0;
    int fails = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int cur_row = -1;
    int seen[FR];
    vec_t vt[4];

    cam_capture_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    cam_capture_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .cap_btn(cap_btn),
        .mode_live(mode_live),
        .frame_done(frame_done),
        .busy(busy),
        .err_line(err_line)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            logic [7:0] e;
            wr_cnt++;
            checks++;
            e = bus.mem_addr[0] ? 8'h1C : 8'hE0;
            if (int'(bus.mem_addr) >= FR) begin
                fails++;
                $display("FAIL wr_addr got=%0d limit=%0d", bus.mem_addr, FR);
            end else begin
                seen[bus.mem_addr]++;
                if (bus.mem_data !== e) begin
                    fails++;
                    $display("FAIL wr_data addr=%0d got=%h exp=%h",
                             bus.mem_addr, bus.mem_data, e);
                end
            end
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic clear_stats();
        wr_cnt = 0;
        done_cnt = 0;
        foreach (seen[i]) seen[i] = 0;
    endtask

    task automatic pclk_byte(input logic [7:0] d, input logic h);
        bus.cam_px_data = d;
        bus.cam_href = h;
        bus.cam_pclk = 1'b0;
        repeat (2) @(negedge clk);
        bus.cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] pat(input int b);
        case (b % 4)
            0: return 8'hF8;
            1: return 8'h00;
            2: return 8'h07;
            default: return 8'hE0;
        endcase
    endfunction

    task automatic send_frame(input int odd_row, input int odd_bytes, input bit drop_live);
        cur_row = -1;
        bus.cam_vsync = 1'b1;
        repeat (8) pclk_byte(8'h00, 1'b0);
        bus.cam_vsync = 1'b0;
        repeat (4) pclk_byte(8'h00, 1'b0);
        for (int r = 0; r < H; r++) begin
            int n;
            n = (r == odd_row) ? odd_bytes : 2 * W;
            cur_row = r;
            for (int b = 0; b < n; b++) pclk_byte(pat(b), 1'b1);
            repeat (4) pclk_byte(8'h00, 1'b0);
            if (drop_live && r == 0) mode_live = 1'b0;
        end
        bus.cam_vsync = 1'b1;
        repeat (4) pclk_byte(8'h00, 1'b0);
    endtask

    task automatic pulse_btn();
        @(negedge clk);
        cap_btn = 1'b1;
        repeat (3) @(negedge clk);
        cap_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_row(input int n);
        int k;
        k = 0;
        while (cur_row < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (cur_row < n) chk("wait_row_timeout", cur_row, n);
    endtask

    function automatic int cov_bad(input int nfr, input int orow, input int obytes);
        int bad = 0;
        for (int a = 0; a < FR; a++) begin
            int lim, e;
            lim = W;
            if (a / W == orow) lim = (obytes / 2 < W) ? obytes / 2 : W;
            e = (a % W < lim) ? nfr : 0;
            if (seen[a] != e) bad++;
        end
        return bad;
    endfunction

    initial begin
        bus.cam_pclk = 1'b0;
        bus.cam_vsync = 1'b1;
        bus.cam_href = 1'b0;
        bus.cam_px_data = 8'h00;
        clear_stats();

        vt[0] = '{0, 1, -1, 0, FR, 1, 0};
        vt[1] = '{1, 3, -1, 0, 3 * FR, 3, 0};
        vt[2] = '{0, 1, 5, 2 * W - 8, FR - 4, 1, 1};
        vt[3] = '{0, 1, 0, 2 * W + 20, FR, 1, 1};

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.mem_wr_en, bus.mem_addr, bus.mem_data, frame_done, busy, err_line}, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            clear_stats();
            mode_live = vt[i].live;
            if (!vt[i].live) pulse_btn();
            for (int f = 0; f < vt[i].nfr; f++)
                send_frame(vt[i].odd_row, vt[i].odd_bytes, vt[i].live && f == vt[i].nfr - 1);
            send_frame(-1, 0, 1'b0);
            repeat (8) @(negedge clk);
            chk($sformatf("v%0d_writes", i), wr_cnt, vt[i].exp_wr);
            chk($sformatf("v%0d_done", i), done_cnt, vt[i].exp_done);
            chk($sformatf("v%0d_err", i), err_line, vt[i].exp_err);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_cov_bad", i),
                cov_bad(vt[i].nfr, vt[i].odd_row, vt[i].odd_bytes), 0);
        end

        // Arm in the middle of a frame: nothing until the next vsync fall
        clear_stats();
        fork
            send_frame(-1, 0, 1'b0);
            begin
                wait_row(3);
                pulse_btn();
                chk("late_busy", busy, 1);
            end
        join
        chk("late_nowr", wr_cnt, 0);
        chk("late_nodone", done_cnt, 0);
        chk("late_err_cleared", err_line, 0);
        send_frame(-1, 0, 1'b0);
        repeat (8) @(negedge clk);
        chk("late_writes", wr_cnt, FR);
        chk("late_done", done_cnt, 1);
        chk("late_cov_bad", cov_bad(1, -1, 0), 0);

        // Reset in the middle of a captured frame
        clear_stats();
        pulse_btn();
        fork
            send_frame(-1, 0, 1'b0);
            begin
                wait_row(4);
                repeat (20) @(negedge clk);
                chk("rst_busy_before", busy, 1);
                chk("rst_addr_before_nz", bus.mem_addr != '0, 1);
                rst = 1'b0;
                #1;
                chk("rst_outputs",
                    {bus.mem_wr_en, bus.mem_addr, bus.mem_data, frame_done, busy, err_line}, 0);
                wr_cnt = 0;
                done_cnt = 0;
                repeat (5) @(negedge clk);
                rst = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        chk("rst_nowr", wr_cnt, 0);
        chk("rst_nodone", done_cnt, 0);
        chk("rst_idle", busy, 0);
        clear_stats();
        pulse_btn();
        send_frame(-1, 0, 1'b0);
        repeat (8) @(negedge clk);
        chk("rst_after_writes", wr_cnt, FR);
        chk("rst_after_done", done_cnt, 1);
        chk("rst_after_cov_bad", cov_bad(1, -1, 0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
